// File: rtl/hc161_updn_mod.sv
// hc161_updn_mod: synchronous up/down modulo-N counter, 161-style cascadable.
// Ports: CP clk, MRN async rst_n, SRN sync clr_n, PEN load_n, CEP/CET enables,
//        UD dir, Dn load data, OVF_CLR; out Qn count, TC term, RCO wrap pulse, OVF sticky.
module hc161_updn_mod #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic             CP,
    input  logic             MRN,
    input  logic             SRN,
    input  logic             PEN,
    input  logic             CEP,
    input  logic             CET,
    input  logic             UD,
    input  logic [WIDTH-1:0] Dn,
    input  logic             OVF_CLR,
    output logic [WIDTH-1:0] Qn,
    output logic             TC,
    output logic             RCO,
    output logic             OVF
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "hc161_updn_mod: WIDTH out of range");
    end

    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_mod
        $fatal(1, "hc161_updn_mod: MODULUS out of range");
    end

    logic             at_top;
    logic             at_zero;
    logic             count_en;
    logic             wrap;
    logic [WIDTH-1:0] q_next;

    // Out-of-range values (>= MODULUS, only reachable by load) wrap upward too.
    assign at_top   = (Qn >= TOP);
    assign at_zero  = (Qn == '0);
    assign count_en = SRN & PEN & CEP & CET;
    assign wrap     = count_en & (UD ? at_top : at_zero);

    // TC uses exact equality so a loaded out-of-range value is not terminal.
    assign TC = CET & (UD ? (Qn == TOP) : at_zero);

    always_comb begin
        q_next = Qn;
        if (!SRN) begin
            q_next = '0;
        end else if (!PEN) begin
            q_next = Dn;
        end else if (CEP && CET) begin
            if (UD) begin
                q_next = at_top ? '0 : Qn + WIDTH'(1);
            end else begin
                q_next = at_zero ? TOP : Qn - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            Qn  <= '0;
            RCO <= 1'b0;
            OVF <= 1'b0;
        end else begin
            Qn  <= q_next;
            RCO <= wrap;
            // A wrap on the same edge as a clear request keeps the flag set.
            if (wrap) begin
                OVF <= 1'b1;
            end else if (OVF_CLR) begin
                OVF <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hc161_updn_mod.sv
// tb_hc161_updn_mod: directed bench for hc161_updn_mod.
// Covers reset, up/down wrap, priority, OVF handling and a two-stage cascade.
module tb_hc161_updn_mod;

    logic       cp = 1'b0;
    logic       mrn = 1'b0;

    logic       srn, pen, cep, cet, ud, ovf_clr;
    logic [3:0] dn;
    logic [3:0] q;
    logic       tc, rco, ovf;

    logic       c_cep;
    logic [3:0] q0, q1;
    logic       tc0, tc1, rco0, rco1, ovf0, ovf1;

    int compared = 0;
    int mismatched = 0;

    always #5 cp = ~cp;

    hc161_updn_mod #(.WIDTH(4), .MODULUS(10)) u_dut (
        .CP(cp), .MRN(mrn), .SRN(srn), .PEN(pen), .CEP(cep), .CET(cet),
        .UD(ud), .Dn(dn), .OVF_CLR(ovf_clr),
        .Qn(q), .TC(tc), .RCO(rco), .OVF(ovf)
    );

    hc161_updn_mod #(.WIDTH(4), .MODULUS(16)) u_lo (
        .CP(cp), .MRN(mrn), .SRN(1'b1), .PEN(1'b1), .CEP(c_cep), .CET(1'b1),
        .UD(1'b1), .Dn(4'h0), .OVF_CLR(1'b0),
        .Qn(q0), .TC(tc0), .RCO(rco0), .OVF(ovf0)
    );

    hc161_updn_mod #(.WIDTH(4), .MODULUS(16)) u_hi (
        .CP(cp), .MRN(mrn), .SRN(1'b1), .PEN(1'b1), .CEP(c_cep), .CET(tc0),
        .UD(1'b1), .Dn(4'h0), .OVF_CLR(1'b0),
        .Qn(q1), .TC(tc1), .RCO(rco1), .OVF(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    int n_lo;
    int n_hi;

    initial begin
        srn = 1'b1; pen = 1'b1; cep = 1'b0; cet = 1'b0;
        ud = 1'b1; ovf_clr = 1'b0; dn = 4'h0; c_cep = 1'b0;

        // T1 reset
        #12;
        check("rst_q", q, 0);
        check("rst_rco", rco, 0);
        check("rst_ovf", ovf, 0);
        @(negedge cp);
        mrn = 1'b1;
        step();
        pen = 1'b0; dn = 4'd7;
        step();
        check("load7", q, 7);
        pen = 1'b1; cep = 1'b1; cet = 1'b1;
        mrn = 1'b0;
        #1;
        check("async_q", q, 0);
        check("async_rco", rco, 0);
        check("async_ovf", ovf, 0);
        #1 mrn = 1'b1;
        step();
        check("first_cnt", q, 1);

        // T2 up wrap
        srn = 1'b0;
        step();
        check("sclr", q, 0);
        srn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("up_q", q, i % 10);
            check("up_rco", rco, (i == 10) ? 1 : 0);
            check("up_tc", tc, (i == 9) ? 1 : 0);
            if (i == 9) begin
                check("up_ovf_pre", ovf, 0);
                cet = 1'b0;
                #1;
                check("up_tc_cet0", tc, 0);
                cet = 1'b1;
            end
        end
        check("up_ovf", ovf, 1);

        // T3 down wrap
        ud = 1'b0; pen = 1'b0; dn = 4'd1;
        step();
        check("dn_load1", q, 1);
        pen = 1'b1;
        step();
        check("dn_q0", q, 0);
        check("dn_tc", tc, 1);
        check("dn_rco0", rco, 0);
        step();
        check("dn_q9", q, 9);
        check("dn_rco", rco, 1);
        pen = 1'b0; dn = 4'd0;
        step();
        pen = 1'b1; cet = 1'b0;
        #1;
        check("dn_tc_cet0", tc, 0);
        step();
        check("dn_hold", q, 0);
        check("dn_hold_rco", rco, 0);

        // T4 priority
        ud = 1'b1; cet = 1'b1; cep = 1'b1;
        srn = 1'b0; pen = 1'b0; dn = 4'd5;
        step();
        check("pri_clr", q, 0);
        check("pri_clr_rco", rco, 0);
        srn = 1'b1; dn = 4'd12;
        step();
        check("pri_load12", q, 12);
        check("pri_load_rco", rco, 0);
        check("pri_tc12", tc, 0);
        pen = 1'b1;
        step();
        check("pri_wrap", q, 0);
        check("pri_wrap_rco", rco, 1);

        // T5 OVF
        cep = 1'b0; ovf_clr = 1'b1;
        step();
        check("ovf_clr0", ovf, 0);
        ovf_clr = 1'b0; pen = 1'b0; dn = 4'd9;
        step();
        check("ovf_load9", ovf, 0);
        check("ovf_load_rco", rco, 0);
        pen = 1'b1; cep = 1'b1; ovf_clr = 1'b1;
        step();
        check("ovf_setwin", ovf, 1);
        check("ovf_q", q, 0);
        cep = 1'b0;
        step();
        check("ovf_clr", ovf, 0);
        ovf_clr = 1'b0;

        // T6 cascade
        check("cas_start", {q1, q0}, 8'h00);
        c_cep = 1'b1;
        n_lo = 0;
        n_hi = 0;
        for (int i = 1; i <= 255; i++) begin
            step();
            if (rco0) n_lo++;
            if (rco1) n_hi++;
        end
        check("cas_ff", {q1, q0}, 8'hFF);
        check("cas_hi_rco_pre", n_hi, 0);
        check("cas_tc1", tc1, 1);
        step();
        if (rco0) n_lo++;
        if (rco1) n_hi++;
        c_cep = 1'b0;
        check("cas_00", {q1, q0}, 8'h00);
        check("cas_hi_rco", n_hi, 1);
        check("cas_lo_rco", n_lo, 16);
        check("cas_hi_ovf", ovf1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
